// File: rtl/cnn_lb_pkg.sv
// cnn_lb_pkg
//   Shared definitions for the 2x2 line buffer sequencer: size-code
//   constants, the size-code to map-width lookup, the window stride rule
//   and the width of window coordinates.
package cnn_lb_pkg;

  localparam int unsigned COORD_W = 5;

  localparam logic [2:0] SEL_W24 = 3'd1;
  localparam logic [2:0] SEL_W12 = 3'd2;
  localparam logic [2:0] SEL_W10 = 3'd3;
  localparam logic [2:0] SEL_W8  = 3'd4;
  localparam logic [2:0] SEL_W4  = 3'd5;

  typedef enum logic {
    STRIDE2 = 1'b0,
    STRIDE1 = 1'b1
  } stride_e;

  // Map width (= height) for a size code; 0 marks an illegal code.
  function automatic logic [COORD_W-1:0] sel_to_w(input logic [2:0] sel);
    logic [COORD_W-1:0] w;
    case (sel)
      SEL_W24: w = 5'd24;
      SEL_W12: w = 5'd12;
      SEL_W10: w = 5'd10;
      SEL_W8:  w = 5'd8;
      SEL_W4:  w = 5'd4;
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic sel_legal(input logic [2:0] sel);
    return sel_to_w(sel) != '0;
  endfunction

endpackage

// File: rtl/lb_valid_pipe.sv
// lb_valid_pipe
//   Fixed-depth shift register carrying {flag, row, col} so the window strobe
//   and its coordinates line up with the line buffer output.
//   clk, rst_n     : clock, asynchronous active-low clear
//   in_flag/row/col: entry of the delay line
//   out_flag/row/col: output after DEPTH cycles
module lb_valid_pipe #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned COORD_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_flag,
  input  logic [COORD_W-1:0] in_row,
  input  logic [COORD_W-1:0] in_col,
  output logic               out_flag,
  output logic [COORD_W-1:0] out_row,
  output logic [COORD_W-1:0] out_col
);

  localparam int unsigned PW = 2 * COORD_W + 1;

  logic [DEPTH-1:0][PW-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= {in_flag, in_row, in_col};
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign {out_flag, out_row, out_col} = sr[DEPTH-1];

endmodule

// File: rtl/linebuffer_2x2_ctrl.sv
// linebuffer_2x2_ctrl
//   Frame sequencer for the 2x2 line buffer. A legal start latches size code,
//   stride rule and base address, then the square map is read from the IFM
//   RAM in raster order (one read per cycle, stalled by hold). Each issued
//   pixel carries a window flag through a delay line matching the RAM and
//   line buffer latency, producing win_valid/win_row/win_col.
//   start, cfg_sel, cfg_stride1, cfg_base : frame request and configuration
//   hold                                  : inhibits new reads only
//   lb_sel                                : size code to the line buffer
//   rd_en, rd_addr                        : IFM RAM read port
//   win_valid, win_row, win_col           : window strobe and coordinates
//   busy, done, cfg_err                   : status
module linebuffer_2x2_ctrl
  import cnn_lb_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned LB_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        cfg_sel,
  input  logic              cfg_stride1,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              hold,
  output logic [2:0]        lb_sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              win_valid,
  output logic [4:0]        win_row,
  output logic [4:0]        win_col,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int unsigned PIPE_D = RD_LAT + LB_LAT;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state;
  stride_e            stride_q;
  logic [COORD_W-1:0] r_q;
  logic [COORD_W-1:0] c_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   drain_cnt;
  logic [COORD_W-1:0] w_cur;

  logic               pix_flag;
  logic [COORD_W-1:0] pix_row;
  logic [COORD_W-1:0] pix_col;

  assign w_cur = sel_to_w(lb_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lb_sel    <= '0;
      stride_q  <= STRIDE2;
      r_q       <= '0;
      c_q       <= '0;
      addr_q    <= '0;
      drain_cnt <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (sel_legal(cfg_sel)) begin
              lb_sel   <= cfg_sel;
              stride_q <= stride_e'(cfg_stride1);
              addr_q   <= cfg_base;
              r_q      <= '0;
              c_q      <= '0;
              state    <= S_RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!hold) begin
            // Raster order makes base + r*W + c a plain running increment.
            addr_q <= addr_q + 1'b1;
            if (c_q == w_cur - 5'd1) begin
              c_q <= '0;
              if (r_q == w_cur - 5'd1) begin
                state     <= S_DRAIN;
                drain_cnt <= '0;
              end else begin
                r_q <= r_q + 5'd1;
              end
            end else begin
              c_q <= c_q + 5'd1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == CNT_W'(PIPE_D - 1)) begin
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_en   = (state == S_RUN) && !hold;
  assign rd_addr = addr_q;
  assign busy    = (state == S_RUN) || (state == S_DRAIN);
  assign done    = (state == S_DONE);

  always_comb begin
    pix_flag = 1'b0;
    pix_row  = '0;
    pix_col  = '0;
    if (stride_q == STRIDE1) begin
      pix_flag = (r_q != '0) && (c_q != '0);
      pix_row  = r_q - 5'd1;
      pix_col  = c_q - 5'd1;
    end else begin
      pix_flag = r_q[0] & c_q[0];
      pix_row  = r_q >> 1;
      pix_col  = c_q >> 1;
    end
  end

  lb_valid_pipe #(
    .DEPTH  (PIPE_D),
    .COORD_W(COORD_W)
  ) u_valid_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_flag (rd_en & pix_flag),
    .in_row  (pix_row),
    .in_col  (pix_col),
    .out_flag(win_valid),
    .out_row (win_row),
    .out_col (win_col)
  );

endmodule

// File: tb/tb_linebuffer_2x2_ctrl.sv
module tb_linebuffer_2x2_ctrl;

  localparam int ADDR_W = 10;
  localparam int RD_LAT = 1;
  localparam int LB_LAT = 1;
  localparam int LAT    = RD_LAT + LB_LAT;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [2:0]        cfg_sel;
  logic              cfg_stride1;
  logic [ADDR_W-1:0] cfg_base;
  logic              hold;
  logic [2:0]        lb_sel;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              win_valid;
  logic [4:0]        win_row;
  logic [4:0]        win_col;
  logic              busy;
  logic              done;
  logic              cfg_err;

  linebuffer_2x2_ctrl #(
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT),
    .LB_LAT(LB_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_sel    (cfg_sel),
    .cfg_stride1(cfg_stride1),
    .cfg_base   (cfg_base),
    .hold       (hold),
    .lb_sel     (lb_sel),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .win_valid  (win_valid),
    .win_row    (win_row),
    .win_col    (win_col),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                cyc;
  } rd_exp_t;

  typedef struct {
    logic [4:0] row;
    logic [4:0] col;
    int         cyc;
  } win_exp_t;

  rd_exp_t  rdq[$];
  win_exp_t winq[$];

  int n_cmp   = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;
  int h0      = 1;
  int h1      = 0;
  int exp_done = -1;
  int win_seen = 0;
  logic [2:0] exp_sel = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle n of a frame is the cycle following edge n-1, edge 0 being the
  // edge that samples start.
  always @(posedge clk) begin
    #2;
    hold = ((cyc - t0 + 1) >= h0) && ((cyc - t0 + 1) <= h1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int w_of(input logic [2:0] sel);
    case (sel)
      3'd1: return 24;
      3'd2: return 12;
      3'd3: return 10;
      3'd4: return 8;
      3'd5: return 4;
      default: return 0;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a read, window or done.
  always @(negedge clk) begin
    int rel;
    rd_exp_t  re;
    win_exp_t we;
    if (rst_n) begin
      rel = cyc - t0 + 1;
      if (rd_en) begin
        if (rdq.size() == 0) chk("rd_en_unexpected", 1, 0);
        else begin
          re = rdq.pop_front();
          chk("rd_addr", int'(rd_addr), int'(re.addr));
          chk("rd_cycle", rel, re.cyc);
        end
      end
      if (win_valid) begin
        win_seen++;
        if (winq.size() == 0) chk("win_unexpected", 1, 0);
        else begin
          we = winq.pop_front();
          chk("win_row", int'(win_row), int'(we.row));
          chk("win_col", int'(win_col), int'(we.col));
          chk("win_cycle", rel, we.cyc);
        end
      end
      if (done) begin
        if (exp_done < 0) chk("done_unexpected", 1, 0);
        else begin
          chk("done_cycle", rel, exp_done);
          exp_done = -1;
        end
      end
      if (busy) chk("lb_sel_in_frame", int'(lb_sel), int'(exp_sel));
    end
  end

  // Builds the expected reads/windows/done for a frame, then issues the start.
  task automatic run_frame(input logic [2:0] sel, input logic s1,
                           input logic [ADDR_W-1:0] base, input int hh0, input int hh1);
    int w, q, r, c;
    rd_exp_t  re;
    win_exp_t we;
    w = w_of(sel);
    q = 0;
    for (int p = 0; p < w * w; p++) begin
      q++;
      while (q >= hh0 && q <= hh1) q++;
      re.addr = ADDR_W'(int'(base) + p);
      re.cyc  = q;
      rdq.push_back(re);
      r = p / w;
      c = p % w;
      if (s1 ? (r >= 1 && c >= 1) : ((r % 2 == 1) && (c % 2 == 1))) begin
        we.row = s1 ? 5'(r - 1) : 5'(r / 2);
        we.col = s1 ? 5'(c - 1) : 5'(c / 2);
        we.cyc = q + LAT;
        winq.push_back(we);
      end
    end
    @(posedge clk); #1;
    exp_done    = q + LAT + 1;
    exp_sel     = sel;
    win_seen    = 0;
    h0          = hh0;
    h1          = hh1;
    t0          = cyc + 1;
    cfg_sel     = sel;
    cfg_stride1 = s1;
    cfg_base    = base;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int n_win);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_done_timeout"}, 0, 1);
    @(negedge clk);
    chk({tag, "_win_count"}, win_seen, n_win);
    chk({tag, "_rd_left"}, rdq.size(), 0);
    chk({tag, "_win_left"}, winq.size(), 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
    rdq.delete();
    winq.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lb_sel"}, int'(lb_sel), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_win_valid"}, int'(win_valid), 0);
    chk({tag, "_win_row"}, int'(win_row), 0);
    chk({tag, "_win_col"}, int'(win_col), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
  endtask

  initial begin
    int cnt;
    rst_n       = 1'b0;
    start       = 1'b0;
    cfg_sel     = 3'd0;
    cfg_stride1 = 1'b0;
    cfg_base    = '0;
    hold        = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // W=4, stride 2: windows at cycles 8,10,16,18, done at 19
    run_frame(3'd5, 1'b0, 10'd0, 1, 0);
    finish_frame("w4_s2", 4);

    // W=4, stride 1, base 100: 9 windows
    run_frame(3'd5, 1'b1, 10'd100, 1, 0);
    finish_frame("w4_s1", 9);

    // W=8, stride 2, hold in cycles 10..14: done at 72
    run_frame(3'd4, 1'b0, 10'd0, 10, 14);
    finish_frame("w8_hold", 16);
    h0 = 1; h1 = 0;

    // Illegal size codes
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      cfg_sel = (k == 0) ? 3'd0 : 3'd7;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("cfg_err_pulse", int'(cfg_err), 1);
      chk("cfg_err_busy", int'(busy), 0);
      chk("cfg_err_lb_sel", int'(lb_sel), 4);
      @(posedge clk); #1;
      chk("cfg_err_one_cycle", int'(cfg_err), 0);
      chk("cfg_err_idle", int'(busy), 0);
    end

    // W=24 frame with a start (sel=2) injected mid-frame
    run_frame(3'd1, 1'b0, 10'd0, 1, 0);
    while (cyc - t0 + 1 < 50) begin
      @(posedge clk); #1;
    end
    cfg_sel = 3'd2;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_no_err", int'(cfg_err), 0);
    chk("busy_start_lb_sel", int'(lb_sel), 1);
    finish_frame("w24_s2", 144);

    // Reset in cycle 8 of a W=4 frame
    run_frame(3'd5, 1'b0, 10'd0, 1, 0);
    while (cyc - t0 + 1 < 8) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    rdq.delete();
    winq.delete();
    exp_done = -1;
    #1;
    chk_all_zero("midreset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (win_valid || done || rd_en) cnt++;
    end
    chk("post_reset_activity", cnt, 0);

    // W=10 frame after the reset
    run_frame(3'd3, 1'b0, 10'd0, 1, 0);
    finish_frame("w10_s2", 25);

    // Address wrap: 1020..1023 then 0..11
    run_frame(3'd5, 1'b1, 10'd1020, 1, 0);
    finish_frame("wrap", 9);
    chk("lb_sel_kept", int'(lb_sel), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0t expected finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
